// File: rtl/mult_pkg.sv
// Shared definitions for the pipelined multiplier and its two-port arbiter.
package mult_pkg;
    localparam int STAGES = 8;
    localparam int DATA_W = 64;

    typedef logic req_id_t;

    typedef struct packed {
        logic    valid;
        req_id_t id;
    } tag_t;
endpackage

// File: rtl/mult.sv
// Fixed-latency pipelined multiplier: done rises exactly STAGES cycles after start.
module mult
    import mult_pkg::*;
#(
    parameter int STAGES = mult_pkg::STAGES
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] mcand,
    input  logic [DATA_W-1:0] mplier,
    output logic              done,
    output logic [DATA_W-1:0] product
);
    logic [STAGES-1:0] vld_p;
    logic [DATA_W-1:0] prod_p [STAGES];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vld_p <= '0;
        end else begin
            vld_p <= {vld_p[STAGES-2:0], start};
        end
    end

    // Product data carries no reset; only the valid chain matters for control.
    always_ff @(posedge clock) begin
        prod_p[0] <= mcand * mplier;
        for (int i = 1; i < STAGES; i++) begin
            prod_p[i] <= prod_p[i-1];
        end
    end

    assign done    = vld_p[STAGES-1];
    assign product = prod_p[STAGES-1];
endmodule

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one pipelined multiplier between two requesters;
// a tag pipeline running in lockstep with the multiplier routes each product back.
module mult_arbiter
    import mult_pkg::*;
#(
    parameter int STAGES = mult_pkg::STAGES
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        req0_valid,
    input  logic [63:0] req0_mcand,
    input  logic [63:0] req0_mplier,
    input  logic        req1_valid,
    input  logic [63:0] req1_mcand,
    input  logic [63:0] req1_mplier,
    output logic        req0_ready,
    output logic        req1_ready,
    output logic        resp0_valid,
    output logic [63:0] resp0_product,
    output logic        resp1_valid,
    output logic [63:0] resp1_product,
    output logic        busy,
    output logic        tag_error
);
    req_id_t           ptr;
    req_id_t           grant_id;
    logic              accept;
    logic              mult_done;
    logic [63:0]       mult_product;
    logic [63:0]       mult_mcand;
    logic [63:0]       mult_mplier;
    tag_t              tags [STAGES];
    tag_t              head;
    logic              retire;

    always_comb begin
        req0_ready = enable && req0_valid && (!req1_valid || ptr == 1'b0);
        req1_ready = enable && req1_valid && (!req0_valid || ptr == 1'b1);
        accept     = req0_ready || req1_ready;
        grant_id   = req1_ready;
        mult_mcand  = '0;
        mult_mplier = '0;
        if (req0_ready) begin
            mult_mcand  = req0_mcand;
            mult_mplier = req0_mplier;
        end else if (req1_ready) begin
            mult_mcand  = req1_mcand;
            mult_mplier = req1_mplier;
        end
    end

    mult #(.STAGES(STAGES)) u_mult (
        .clock   (clock),
        .reset   (reset),
        .start   (accept),
        .mcand   (mult_mcand),
        .mplier  (mult_mplier),
        .done    (mult_done),
        .product (mult_product)
    );

    assign head   = tags[STAGES-1];
    // A response only issues when the multiplier and tag head agree.
    assign retire = mult_done && head.valid;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr           <= 1'b0;
            resp0_valid   <= 1'b0;
            resp1_valid   <= 1'b0;
            resp0_product <= '0;
            resp1_product <= '0;
            tag_error     <= 1'b0;
            for (int i = 0; i < STAGES; i++) begin
                tags[i] <= '0;
            end
        end else begin
            if (accept) begin
                ptr <= ~grant_id;
            end
            tags[0] <= '{valid: accept, id: grant_id};
            for (int i = 1; i < STAGES; i++) begin
                tags[i] <= tags[i-1];
            end
            resp0_valid <= retire && (head.id == 1'b0);
            resp1_valid <= retire && (head.id == 1'b1);
            if (retire && head.id == 1'b0) begin
                resp0_product <= mult_product;
            end
            if (retire && head.id == 1'b1) begin
                resp1_product <= mult_product;
            end
            if (mult_done != head.valid) begin
                tag_error <= 1'b1;
            end
        end
    end

    always_comb begin
        busy = resp0_valid || resp1_valid;
        for (int i = 0; i < STAGES; i++) begin
            busy = busy || tags[i].valid;
        end
    end
endmodule

// File: tb/tb_mult_arbiter.sv
// Scoreboard bench for mult_arbiter: a stimulus process predicts grants and
// products, a monitor process retires them against the DUT responses.
module tb_mult_arbiter;
    import mult_pkg::*;

    localparam int LAT = STAGES + 1;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic        req0_valid, req1_valid;
    logic [63:0] req0_mcand, req0_mplier, req1_mcand, req1_mplier;
    logic        req0_ready, req1_ready;
    logic        resp0_valid, resp1_valid;
    logic [63:0] resp0_product, resp1_product;
    logic        busy, tag_error;

    mult_arbiter #(.STAGES(STAGES)) dut (
        .clock         (clock),
        .reset         (reset),
        .enable        (enable),
        .req0_valid    (req0_valid),
        .req0_mcand    (req0_mcand),
        .req0_mplier   (req0_mplier),
        .req1_valid    (req1_valid),
        .req1_mcand    (req1_mcand),
        .req1_mplier   (req1_mplier),
        .req0_ready    (req0_ready),
        .req1_ready    (req1_ready),
        .resp0_valid   (resp0_valid),
        .resp0_product (resp0_product),
        .resp1_valid   (resp1_valid),
        .resp1_product (resp1_product),
        .busy          (busy),
        .tag_error     (tag_error)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int          id;
        logic [63:0] prod;
        int          acc;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    bit   m_ptr  = 1'b0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void flag(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endfunction

    // One cycle of stimulus; the reference favours the pointer holder only under contention.
    task automatic drive(input bit en, input bit v0, input logic [63:0] a0, input logic [63:0] b0,
                         input bit v1, input logic [63:0] a1, input logic [63:0] b1);
        bit   g0, g1;
        exp_t e;
        @(posedge clock);
        #1;
        enable      = en;
        req0_valid  = v0;
        req0_mcand  = a0;
        req0_mplier = b0;
        req1_valid  = v1;
        req1_mcand  = a1;
        req1_mplier = b1;
        @(negedge clock);
        g0 = en && v0 && (!v1 || m_ptr == 1'b0);
        g1 = en && v1 && (!v0 || m_ptr == 1'b1);
        chk("req0_ready", req0_ready, g0);
        chk("req1_ready", req1_ready, g1);
        if (g0 || g1) begin
            e.id   = g1 ? 1 : 0;
            e.prod = g1 ? a1 * b1 : a0 * b0;
            e.acc  = cyc;
            e.due  = cyc + LAT;
            sb.push_back(e);
            m_ptr = g0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 64'd0, 64'd0, 1'b0, 64'd0, 64'd0);
    endtask

    task automatic do_reset();
        @(posedge clock);
        #1;
        reset      = 1'b1;
        enable     = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        sb.delete();
        m_ptr = 1'b0;
        @(negedge clock);
        chk("rst_req0_ready", req0_ready, 1'b0);
        chk("rst_req1_ready", req1_ready, 1'b0);
        chk("rst_resp0_valid", resp0_valid, 1'b0);
        chk("rst_resp1_valid", resp1_valid, 1'b0);
        chk("rst_resp0_product", resp0_product, 64'd0);
        chk("rst_resp1_product", resp1_product, 64'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_tag_error", tag_error, 1'b0);
        reset = 1'b0;
    endtask

    exp_t mon_e;
    bit   exp_busy;
    always @(negedge clock) begin
        if (!reset) begin
            exp_busy = resp0_valid || resp1_valid || (sb.size() > 0 && sb[0].acc < cyc);
            chk("busy", busy, exp_busy);
            chk("tag_error", tag_error, 1'b0);
            if (resp0_valid && resp1_valid) flag("two responses in one cycle");
            if (resp0_valid || resp1_valid) begin
                if (sb.size() == 0) begin
                    flag("unexpected response");
                end else begin
                    mon_e = sb.pop_front();
                    chk("resp_id", resp1_valid ? 64'd1 : 64'd0, 64'(mon_e.id));
                    chk("resp_product", resp1_valid ? resp1_product : resp0_product, mon_e.prod);
                    chk("resp_cycle", 64'(cyc), 64'(mon_e.due));
                end
            end else if (sb.size() > 0 && sb[0].acc < cyc && sb[0].due <= cyc) begin
                flag("missing response");
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        reset       = 1'b1;
        enable      = 1'b0;
        req0_valid  = 1'b0;
        req1_valid  = 1'b0;
        req0_mcand  = '0;
        req0_mplier = '0;
        req1_mcand  = '0;
        req1_mplier = '0;
        repeat (2) @(posedge clock);
        do_reset();

        // Single op on requester 0
        drive(1'b1, 1'b1, 64'd3, 64'd5, 1'b0, 64'd0, 64'd0);
        idle(12);

        // Contention straight after reset: grants alternate 0,1,0,1
        do_reset();
        for (int k = 0; k < 4; k++)
            drive(1'b1, 1'b1, 64'(k + 2), 64'd10, 1'b1, 64'(k + 7), 64'd100);
        idle(12);

        // Back-to-back on requester 1
        for (int k = 1; k <= 8; k++)
            drive(1'b1, 1'b0, 64'd0, 64'd0, 1'b1, 64'(k), 64'(k));
        idle(12);

        // Wrap-around product and an enable gap mid-stream
        drive(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b0, 64'd0, 64'd0);
        drive(1'b1, 1'b1, 64'd7, 64'd9, 1'b1, 64'd11, 64'd13);
        for (int k = 0; k < 3; k++)
            drive(1'b0, 1'b1, 64'd1, 64'd1, 1'b1, 64'd2, 64'd2);
        drive(1'b1, 1'b1, 64'd6, 64'd6, 1'b1, 64'd8, 64'd8);
        idle(12);

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            drive($urandom_range(0, 9) != 0, 1'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
                  1'($urandom), {$urandom, $urandom}, 64'($urandom_range(0, 1000)));
        end
        idle(12);

        // Reset with three ops in flight: nothing may come out afterwards
        for (int k = 0; k < 3; k++)
            drive(1'b1, 1'b1, 64'(k + 1), 64'd3, 1'b0, 64'd0, 64'd0);
        idle(2);
        do_reset();
        idle(15);

        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        chk("final_tag_error", tag_error, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 Parameter: STAGES, 8, multiplier pipeline depth; it SHALL equal the mult instance depth.
REQ-002 Port: clock  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: enable  input  1  when low, no new grants; in-flight ops still complete.
REQ-005 Port: req0_valid / req1_valid  input  1 each  requester i has an operation pending.
REQ-006 Port: req0_mcand, req0_mplier / req1_mcand, req1_mplier  input  64 each  unsigned operands.
REQ-007 Port: req0_ready / req1_ready  output  1 each  grant; combinational from valids, enable and pointer.
REQ-008 Port: resp0_valid / resp1_valid  output  1 each  registered one-cycle pulse; product for requester i.
REQ-009 Port: resp0_product / resp1_product  output  64 each  low 64 bits of mcand*mplier, held until the next pulse.
REQ-010 Port: busy  output  1  high when any op is in flight or a response is pending output.
REQ-011 Port: tag_error  output  1  sticky; set when mult done disagrees with the tag pipeline head.

Function
REQ-012 At most one of req0_ready/req1_ready SHALL be high per cycle; both SHALL be low when enable=0.
REQ-013 Only one valid: that requester SHALL be granted regardless of the pointer.
REQ-014 Both valid: the requester named by the round-robin pointer SHALL be granted.
REQ-015 On any accept (valid&&ready), the pointer SHALL move to the other requester; with no accept it SHALL hold.
REQ-016 Accept cycle: mult start=1 and the granted operands SHALL drive mult mcand/mplier in that same cycle; otherwise start=0, operands 0.
REQ-017 Requester handshake SHALL never stall for capacity; the pipeline accepts one op per cycle.
REQ-018 A tag shift register of STAGES entries {valid, id} SHALL shift every cycle; entry 0 loads {accept, granted id}.
REQ-019 The tag head SHALL align with mult done exactly STAGES cycles after the accept cycle.
REQ-020 When done=1 and the head is valid, the head id SHALL route product to resp<id>_product and pulse resp<id>_valid on the next edge.
REQ-021 Accept-to-resp_valid latency SHALL be exactly STAGES+1 cycles; back-to-back accepts SHALL give back-to-back responses in order.
REQ-022 Simultaneous accept and retirement in one cycle SHALL both proceed with no bubble.
REQ-023 done != head.valid in any cycle SHALL set tag_error; it SHALL stay set until reset, and no response SHALL issue that cycle.
REQ-024 Deasserting enable mid-stream SHALL not disturb in-flight ops, which SHALL complete with normal latency.

Reset
REQ-025 Reset asserted: all tag entries invalid, pointer=0 (requester 0 favoured), resp*_valid=0, resp*_product=0, busy=0, tag_error=0.
REQ-026 The mult instance SHALL share the same reset; in-flight ops SHALL be discarded with no response after reset release.
REQ-027 First cycle after release: accepts SHALL be allowed if enable=1.

Structure
REQ-028 STAGES and the 1-bit requester-id typedef SHALL live in a shared mult_pkg package, also used by mult.
REQ-029 Exactly one sub-module SHALL be instantiated: mult (existing pipelined multiplier), driven only by this arbiter.

Verification
REQ-030 Single op: req0 3*5 accepted at cycle 0 -> resp0_valid pulses at cycle 9 with product 15; resp1_valid stays 0.
REQ-031 Contention: both valid for 4 cycles after reset -> grants 0,1,0,1; responses alternate resp0/resp1 at cycles 9-12.
REQ-032 Back-to-back: req1 valid 8 consecutive cycles, operands k*k for k=1..8 -> 8 consecutive resp1 pulses with 1,4,...,64; busy high throughout.
REQ-033 Wrap: 0xFFFFFFFFFFFFFFFF * 2 -> product 0xFFFFFFFFFFFFFFFE; enable=0 for 3 cycles mid-stream -> no grants, in-flight ops still complete.
REQ-034 Reset mid-flight: 3 ops in flight, reset pulsed one cycle -> no resp pulses afterward, all outputs 0, tag_error=0.
